mux_n_reg_scan: RTL and testbench

//  - Parametrised, registered N-to-1 multiplexer of W-bit channels; next generation of the 2-bit 3:1 mux labs.
//  - Replaces the implicit latch on an unmapped select with explicit, registered bad-select handling.
//  - Adds an auto-scan mode that cycles through the channels with a programmable dwell time.
//  - Sits between a bank of W-bit sources (switches, counters) and a single display/consumer.

---
 rtl/mux_pkg.sv | 23 ++
 rtl/mux_n_comb.sv | 29 ++
 rtl/mux_n_reg_scan.sv | 124 ++++++++++++
 tb/tb_mux_n_reg_scan.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the registered N:1 multiplexer with auto-scan.
package mux_pkg;

    // Operating mode of the multiplexer.
    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_n_comb.sv
// Purely combinational W-bit N:1 selector with an in-range flag.
module mux_n_comb
    import mux_pkg::*;
#(
    parameter int W    = 2,
    parameter int N    = 3,
    parameter int SELW = 2
) (
    input  logic [N*W-1:0]  in_bus,
    input  logic [SELW-1:0] sel,
    output logic [W-1:0]    y,
    output logic            in_range
);

    // One extra bit so N == 2**SELW is representable.
    localparam logic [SELW:0] N_V = N[SELW:0];

    // Pick channel sel; out-of-range selects yield zero and in_range=0.
    always_comb begin
        y        = '0;
        in_range = ({1'b0, sel} < N_V);
        for (int k = 0; k < N; k++) begin
            if (sel == SELW'(k)) begin
                y = in_bus[k*W +: W];
            end
        end
    end

endmodule

// File: rtl/mux_n_reg_scan.sv
// Registered N:1 multiplexer with explicit bad-select handling and an
// auto-scan mode that dwells DWELL cycles on each channel in turn.
module mux_n_reg_scan
    import mux_pkg::*;
#(
    parameter int W     = 2,
    parameter int N     = 3,
    parameter int SELW  = 2,
    parameter int DWELL = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N*W-1:0]  in_bus,
    input  logic [SELW-1:0] sel,
    input  logic            scan_en,
    input  logic            hold_on_bad,
    output logic [W-1:0]    y,
    output logic            y_valid,
    output logic            bad_sel,
    output logic [SELW-1:0] cur_ch
);

    localparam int CNTW = (clog2(DWELL) > 0) ? clog2(DWELL) : 1;
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(DWELL - 1);
    localparam logic [SELW-1:0] LAST_CH  = SELW'(N - 1);

    state_t          state, state_d;
    logic [CNTW-1:0] cnt, cnt_d, cnt_step;
    logic [W-1:0]    y_d;
    logic            y_valid_d, bad_sel_d;
    logic [SELW-1:0] cur_ch_d, nxt_ch, scan_ch;

    logic [W-1:0]    sel_data, scan_data;
    logic            sel_ok, scan_ok;

    // Manual path: channel addressed by the external select.
    mux_n_comb #(.W(W), .N(N), .SELW(SELW)) u_sel_mux (
        .in_bus   (in_bus),
        .sel      (sel),
        .y        (sel_data),
        .in_range (sel_ok)
    );

    // Scan path: next channel to show (channel 0 on scan entry).
    mux_n_comb #(.W(W), .N(N), .SELW(SELW)) u_scan_mux (
        .in_bus   (in_bus),
        .sel      (scan_ch),
        .y        (scan_data),
        .in_range (scan_ok)
    );

    // Dwell bookkeeping: advance channel only when the dwell counter wraps.
    always_comb begin
        cnt_step = (cnt == LAST_CNT) ? '0 : cnt + CNTW'(1);
        nxt_ch   = cur_ch;
        if (cnt == LAST_CNT) begin
            nxt_ch = (cur_ch == LAST_CH) ? '0 : cur_ch + SELW'(1);
        end
        scan_ch = (state == ST_SCAN) ? nxt_ch : '0;
    end

    // Next-state and next-output decode; registers hold unless overridden.
    always_comb begin
        state_d   = scan_en ? ST_SCAN : ST_MANUAL;
        y_d       = y;
        y_valid_d = y_valid;
        bad_sel_d = bad_sel;
        cur_ch_d  = cur_ch;
        cnt_d     = cnt;
        if (scan_en) begin
            y_d       = scan_data;
            y_valid_d = scan_ok;
            bad_sel_d = 1'b0;
            if (state == ST_SCAN) begin
                cur_ch_d = nxt_ch;
                cnt_d    = cnt_step;
            end else begin
                cur_ch_d = '0;
                cnt_d    = '0;
            end
        end else begin
            cnt_d = '0;
            if (sel_ok) begin
                y_d       = sel_data;
                y_valid_d = 1'b1;
                bad_sel_d = 1'b0;
                cur_ch_d  = sel;
            end else begin
                bad_sel_d = 1'b1;
                if (!hold_on_bad) begin
                    y_d       = '0;
                    y_valid_d = 1'b0;
                end
            end
        end
    end

    // Mode register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_MANUAL;
        end else begin
            state <= state_d;
        end
    end

    // Output and dwell-counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y       <= '0;
            y_valid <= 1'b0;
            bad_sel <= 1'b0;
            cur_ch  <= '0;
            cnt     <= '0;
        end else begin
            y       <= y_d;
            y_valid <= y_valid_d;
            bad_sel <= bad_sel_d;
            cur_ch  <= cur_ch_d;
            cnt     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mux_n_reg_scan.sv
// Scoreboard bench for mux_n_reg_scan (W=2, N=3, SELW=2, DWELL=4).
module tb_mux_n_reg_scan;

    localparam int W     = 2;
    localparam int N     = 3;
    localparam int SELW  = 2;
    localparam int DWELL = 4;

    // ch2=10, ch1=01, ch0=00 ; B1 has ch1 changed to 11
    localparam logic [N*W-1:0] B0 = 6'b10_01_00;
    localparam logic [N*W-1:0] B1 = 6'b10_11_00;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N*W-1:0]  in_bus = B0;
    logic [SELW-1:0] sel = '0;
    logic            scan_en = 1'b0;
    logic            hold_on_bad = 1'b1;
    logic [W-1:0]    y;
    logic            y_valid;
    logic            bad_sel;
    logic [SELW-1:0] cur_ch;

    always #5 clk = ~clk;

    mux_n_reg_scan #(.W(W), .N(N), .SELW(SELW), .DWELL(DWELL)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_bus      (in_bus),
        .sel         (sel),
        .scan_en     (scan_en),
        .hold_on_bad (hold_on_bad),
        .y           (y),
        .y_valid     (y_valid),
        .bad_sel     (bad_sel),
        .cur_ch      (cur_ch)
    );

    typedef struct {
        logic [1:0] y;
        logic       v;
        logic       b;
        logic [1:0] ch;
        int         tag;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    // Monitor: every edge with an outstanding expectation is checked at the following negedge.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (y !== e.y || y_valid !== e.v || bad_sel !== e.b || cur_ch !== e.ch) begin
                failures++;
                $display("FAIL step%0d: got y=%b v=%b bad=%b ch=%0d, want y=%b v=%b bad=%b ch=%0d",
                         e.tag, y, y_valid, bad_sel, cur_ch, e.y, e.v, e.b, e.ch);
            end
        end
    end

    task automatic drive(input logic [N*W-1:0] bus, input logic [1:0] s, input logic se,
                         input logic hb, input logic [1:0] ey, input logic ev, input logic eb,
                         input logic [1:0] ech, input int tag);
        exp_t e;
        in_bus = bus;
        sel = s;
        scan_en = se;
        hold_on_bad = hb;
        e.y = ey; e.v = ev; e.b = eb; e.ch = ech; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic step(input logic [N*W-1:0] bus, input logic [1:0] s, input logic se,
                        input logic hb, input logic [1:0] ey, input logic ev, input logic eb,
                        input logic [1:0] ech, input int tag);
        @(negedge clk);
        #1;
        drive(bus, s, se, hb, ey, ev, eb, ech, tag);
    endtask

    task automatic chk_now(input string name, input logic [1:0] ey, input logic ev,
                           input logic eb, input logic [1:0] ech);
        checks++;
        if (y !== ey || y_valid !== ev || bad_sel !== eb || cur_ch !== ech) begin
            failures++;
            $display("FAIL %s: got y=%b v=%b bad=%b ch=%0d, want y=%b v=%b bad=%b ch=%0d",
                     name, y, y_valid, bad_sel, cur_ch, ey, ev, eb, ech);
        end
    endtask

    task automatic drain();
        @(negedge clk);
        #2;
    endtask

    logic [1:0] sc_ch [21] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2,
                               2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
    logic [1:0] sc_y  [21] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10,
                               2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    logic [1:0] rs_ch [5]  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
    logic [1:0] rs_y  [5]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01};

    initial begin
        repeat (2) @(negedge clk);
        chk_now("por", 2'b00, 1'b0, 1'b0, 2'd0);
        reset = 1'b0;

        // run a little, then reset asynchronously mid-cycle
        step(B0, 2'd2, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 2'd2, 1);
        step(B0, 2'd1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 2'd1, 2);
        drain();
        reset = 1'b1;
        #1;
        chk_now("async_rst", 2'b00, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        drive(B0, 2'd1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 2'd1, 3);

        // sel sweep
        step(B0, 2'd0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 2'd0, 10);
        step(B0, 2'd1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 2'd1, 11);
        step(B0, 2'd2, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 2'd2, 12);

        // bad select, hold
        step(B0, 2'd2, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 2'd2, 20);
        step(B0, 2'd3, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 2'd2, 21);
        step(B0, 2'd0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 2'd0, 22);

        // bad select, force zero
        step(B0, 2'd1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 2'd1, 30);
        step(B0, 2'd3, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'd1, 31);

        // scan; ch1 becomes 11 mid-dwell; sel/hold ignored
        for (int i = 0; i < 21; i++) begin
            step((i >= 5 && i <= 7) ? B1 : B0, 2'd3, 1'b1, 1'b0,
                 sc_y[i], 1'b1, 1'b0, sc_ch[i], 100 + i);
        end

        // leave scan on ch2 with sel=01
        step(B0, 2'd1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 2'd1, 200);

        // re-enter scan: full dwell on ch0
        for (int i = 0; i < 5; i++) begin
            step(B0, 2'd2, 1'b1, 1'b1, rs_y[i], 1'b1, 1'b0, rs_ch[i], 210 + i);
        end

        // reset mid-scan, then the first edge is a scan entry
        drain();
        reset = 1'b1;
        #1;
        chk_now("rst_in_scan", 2'b00, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        drive(B0, 2'd2, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 2'd0, 300);
        step(B0, 2'd2, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 2'd0, 301);
        step(B0, 2'd2, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 2'd2, 302);

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(negedge clk);
            #2;
        end
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
